// File: rtl/reply_fifo_pkg.sv
// Shared sizing helpers for the reply FIFO family.
package reply_fifo_pkg;

  // Pointer / occupancy field width for a FIFO of the given depth:
  // one extra bit over the address so that full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_1r1w.sv
// WIDTH x DEPTH storage with one synchronous write port and one synchronous,
// registered read port. The storage array itself is not reset; only the read
// output register is.
module fifo_ram_1r1w #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
  output logic [WIDTH-1:0]           rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register: loads on a read, otherwise holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/reply_fifo_pkt.sv
// Reply FIFO between the JTAG command executor (writer) and the UART
// transmitter (reader) with frame-atomic commit/discard. The writer fills a
// frame speculatively behind wr_ptr; only entries below cmt_ptr are visible to
// the reader.
//
// Handshake: a write is accepted on any edge where wr_en=1 and full=0; a read
// is accepted on any edge where rd_en=1 and empty=0, and its data appears on
// rd_data with rd_valid=1 during the following cycle. full/empty are the only
// back-pressure; requests made while blocked are ignored (a blocked write also
// sets the sticky overflow flag).
module reply_fifo_pkt
  import reply_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 256,
  parameter int AF_THRESH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       commit,
  input  logic                       discard,
  output logic                       full,
  output logic                       almost_full,
  output logic [ptr_w(DEPTH)-1:0]    free,
  output logic                       overflow,
  input  logic                       clr_overflow,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic [ptr_w(DEPTH)-1:0]    avail
);

  localparam int            CW      = ptr_w(DEPTH);
  localparam int            AW      = CW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   AF_T    = 32'(AF_THRESH);

  // Reject parameter sets the pointer arithmetic cannot support.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || AF_THRESH < 0) begin : g_bad_param
    $error("reply_fifo_pkt: DEPTH must be a power of two >= 4 and AF_THRESH >= 0");
  end

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] wr_ptr_inc;
  logic          overflow_q, overflow_d;
  logic          rd_valid_q;
  logic          wr_ok;
  logic          rd_ok;

  // Status is derived purely from the registered pointers.
  assign free        = DEPTH_C - (wr_ptr_q - rd_ptr_q);
  assign avail       = cmt_ptr_q - rd_ptr_q;
  assign full        = (free == '0);
  assign empty       = (avail == '0);
  assign almost_full = (32'(free) <= AF_T);
  assign overflow    = overflow_q;
  assign rd_valid    = rd_valid_q;

  // Acceptance uses current-state flags only; a same-cycle read frees no space.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Next-state pointer and overflow logic; discard takes priority over commit.
  always_comb begin
    wr_ptr_inc = wr_ptr_q + {{(CW-1){1'b0}}, wr_ok};
    wr_ptr_d   = wr_ptr_inc;
    cmt_ptr_d  = cmt_ptr_q;
    rd_ptr_d   = rd_ptr_q + {{(CW-1){1'b0}}, rd_ok};
    overflow_d = overflow_q;
    if (discard) begin
      wr_ptr_d = cmt_ptr_q;
    end else if (commit) begin
      cmt_ptr_d = wr_ptr_inc;
    end
    if (clr_overflow) begin
      overflow_d = 1'b0;
    end
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
  end

  // Pointer, overflow and read-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cmt_ptr_q  <= cmt_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_ok;
    end
  end

  fifo_ram_1r1w #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_ok && !discard),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_ok),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

endmodule
